frame_decoder: RTL and testbench

Read-side counterpart of the frame encoder. On a frame start it walks the packed frame-buffer SRAM in raster order, unpacks each SRAM word into its color-code pixels, and streams them out one pixel at a time over a valid/ready interface with (h, v) coordinates. It sits between the frame-buffer SRAM and the display/colour-palette stage.

---
 rtl/frame_decoder.sv | 215 +++++++++++++++++++++
 tb/tb_frame_decoder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_decoder.sv
// frame_decoder: walks the packed frame-buffer SRAM in raster order and streams one colour code per pixel with (h, v).
// Latency: first o_pix_valid RD_LATENCY+2 cycles after i_frame_start; a READ/WAIT bubble separates words.
// Backpressure: i_pix_ready low freezes all pixel outputs; no SRAM word is dropped or re-read.
// Build option: define FRAME_DECODER_PREFETCH_EN to fetch word n+1 while word n is emitted (no bubble).
// Ports: i_clk/i_rst_n; i_frame_start; o_pix_valid/i_pix_ready/o_pix_color/o_pix_h/o_pix_v;
//        o_sram_addr/o_sram_rd/i_sram_data; o_busy (not IDLE), o_done (one-cycle end-of-frame pulse).
module frame_decoder #(
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 16,
    parameter int COLOR_WIDTH = 4,
    parameter int RD_LATENCY  = 2,
    localparam int H_W = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int V_W = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_frame_start,
    input  logic                   i_pix_ready,
    output logic                   o_pix_valid,
    output logic [COLOR_WIDTH-1:0] o_pix_color,
    output logic [H_W-1:0]         o_pix_h,
    output logic [V_W-1:0]         o_pix_v,
    output logic [ADDR_WIDTH-1:0]  o_sram_addr,
    output logic                   o_sram_rd,
    input  logic [DATA_WIDTH-1:0]  i_sram_data,
    output logic                   o_busy,
    output logic                   o_done
);
    localparam int PPW    = DATA_WIDTH / COLOR_WIDTH;
    localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_EMIT, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [H_W-1:0]          h_q, h_d;
    logic [V_W-1:0]          v_q, v_d;
    logic [LANE_W-1:0]       lane_q, lane_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    // One bit per read in flight; the top bit marks the cycle its data is on i_sram_data.
    logic [RD_LATENCY-1:0]   pipe_q, pipe_d;
    logic                    rd_now, accept, last_lane, last_pix, arrive;

`ifdef FRAME_DECODER_PREFETCH_EN
    localparam int NWORDS = (IMG_W * IMG_H) / PPW;
    logic [DATA_WIDTH-1:0]   pf_word_q, pf_word_d;
    logic                    pf_full_q, pf_full_d;   // prefetched word captured, waiting for use
    logic                    pf_pend_q, pf_pend_d;   // prefetch read issued, data not yet returned
    logic                    pf_rd_q, pf_rd_d;
    logic                    new_word;
    assign rd_now = (state_q == S_READ) || pf_rd_q;
`else
    assign rd_now = (state_q == S_READ);
`endif

    assign accept    = (state_q == S_EMIT) && i_pix_ready;
    assign last_lane = (lane_q == LANE_W'(PPW - 1));
    assign last_pix  = (h_q == H_W'(IMG_W - 1)) && (v_q == V_W'(IMG_H - 1));
    assign arrive    = pipe_q[RD_LATENCY-1];

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        lane_d  = lane_q;
        word_d  = word_q;
        addr_d  = addr_q;
        pipe_d[0] = rd_now;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
`ifdef FRAME_DECODER_PREFETCH_EN
        pf_word_d = pf_word_q;
        pf_full_d = pf_full_q;
        pf_pend_d = pf_pend_q;
        pf_rd_d   = 1'b0;
        new_word  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_frame_start) begin
                    state_d = S_READ;
                    addr_d  = '0;
                    h_d     = '0;
                    v_d     = '0;
                    lane_d  = '0;
`ifdef FRAME_DECODER_PREFETCH_EN
                    pf_full_d = 1'b0;
                    pf_pend_d = 1'b0;
`endif
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                if (arrive) begin
                    word_d  = i_sram_data;
                    lane_d  = '0;
                    state_d = S_EMIT;
`ifdef FRAME_DECODER_PREFETCH_EN
                    pf_pend_d = 1'b0;
                    new_word  = 1'b1;
`endif
                end
            end
            S_EMIT: begin
`ifdef FRAME_DECODER_PREFETCH_EN
                // Only prefetch reads can land while emitting.
                if (arrive) begin
                    pf_word_d = i_sram_data;
                    pf_full_d = 1'b1;
                    pf_pend_d = 1'b0;
                end
`endif
                if (accept) begin
                    lane_d = lane_q + 1'b1;
                    if (h_q == H_W'(IMG_W - 1)) begin
                        h_d = '0;
                        v_d = v_q + 1'b1;
                    end else begin
                        h_d = h_q + 1'b1;
                    end
                    if (last_lane) begin
                        lane_d = '0;
                        if (last_pix) begin
                            state_d = S_DONE;
                        end else begin
`ifdef FRAME_DECODER_PREFETCH_EN
                            if (pf_full_q) begin
                                word_d    = pf_word_q;
                                pf_full_d = 1'b0;
                                new_word  = 1'b1;
                            end else if (arrive) begin
                                // Data returning this very cycle: bypass the prefetch buffer.
                                word_d    = i_sram_data;
                                pf_full_d = 1'b0;
                                new_word  = 1'b1;
                            end else if (pf_pend_q) begin
                                state_d = S_WAIT;
                            end else begin
                                addr_d  = addr_q + 1'b1;
                                state_d = S_READ;
                            end
`else
                            addr_d  = addr_q + 1'b1;
                            state_d = S_READ;
`endif
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef FRAME_DECODER_PREFETCH_EN
        // Starting a new word: addr_q is that word, so fetch the following one if it exists.
        if (new_word && (addr_q != ADDR_WIDTH'(NWORDS - 1))) begin
            pf_rd_d   = 1'b1;
            pf_pend_d = 1'b1;
            addr_d    = addr_q + 1'b1;
        end
`endif
    end

    always_comb begin
        o_pix_color = '0;
        for (int k = 0; k < PPW; k++) begin
            if (lane_q == LANE_W'(k)) begin
                o_pix_color = word_q[k*COLOR_WIDTH +: COLOR_WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            lane_q  <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            pipe_q  <= '0;
`ifdef FRAME_DECODER_PREFETCH_EN
            pf_word_q <= '0;
            pf_full_q <= 1'b0;
            pf_pend_q <= 1'b0;
            pf_rd_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            pipe_q  <= pipe_d;
`ifdef FRAME_DECODER_PREFETCH_EN
            pf_word_q <= pf_word_d;
            pf_full_q <= pf_full_d;
            pf_pend_q <= pf_pend_d;
            pf_rd_q   <= pf_rd_d;
`endif
        end
    end

    assign o_pix_valid = (state_q == S_EMIT);
    assign o_pix_h     = h_q;
    assign o_pix_v     = v_q;
    assign o_sram_addr = addr_q;
    assign o_sram_rd   = rd_now;
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = (state_q == S_DONE);

endmodule

// File: tb/tb_frame_decoder.sv
// tb_frame_decoder: scoreboard bench for a 4x2 frame of 4-bit pixels in 16-bit words.
// Main DUT uses RD_LATENCY=2; two side DUTs (RD_LATENCY=1 and 3) check first-valid latency and data.
// Stimulus pushes expected pixels into a queue; a forked monitor pops and compares on valid&ready.
module tb_frame_decoder;
    localparam int W = 4;
    localparam int H = 2;
`ifdef FRAME_DECODER_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif
    localparam int DONE_OFF = PF ? 12 : 15;
    localparam int RST_OFF  = PF ? 6 : 9;
    localparam int RST_LEFT = PF ? 6 : 4;

    typedef struct {
        logic [3:0] c;
        logic [1:0] h;
        logic [0:0] v;
        int         off;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, start, ready, start_x;
    int          cyc = 0;

    logic        pix_vld, sram_rd, busy, done;
    logic [3:0]  pix_col;
    logic [1:0]  pix_h;
    logic [0:0]  pix_row;
    logic [19:0] sram_addr;
    logic [15:0] sram_dat;

    logic        v1, rd1, busy1, done1, v3, rd3, busy3, done3;
    logic [3:0]  c1, c3;
    logic [1:0]  h1, h3;
    logic [0:0]  r1, r3;
    logic [19:0] a1, a3;
    logic [15:0] d1, d3;

    logic [15:0] p2 [0:1];
    logic [15:0] p1;
    logic [15:0] p3 [0:2];

    exp_t        q[$];
    logic [19:0] rd_addrs[$];
    int          checks = 0, errors = 0;
    int          done_cnt, rd_cnt, exp_done, start_cyc, startx_cyc, n1, n3;

    frame_decoder #(.IMG_W(W), .IMG_H(H), .RD_LATENCY(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(start), .i_pix_ready(ready),
        .o_pix_valid(pix_vld), .o_pix_color(pix_col), .o_pix_h(pix_h), .o_pix_v(pix_row),
        .o_sram_addr(sram_addr), .o_sram_rd(sram_rd), .i_sram_data(sram_dat),
        .o_busy(busy), .o_done(done));

    frame_decoder #(.IMG_W(W), .IMG_H(H), .RD_LATENCY(1)) dut_l1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(start_x), .i_pix_ready(1'b1),
        .o_pix_valid(v1), .o_pix_color(c1), .o_pix_h(h1), .o_pix_v(r1),
        .o_sram_addr(a1), .o_sram_rd(rd1), .i_sram_data(d1),
        .o_busy(busy1), .o_done(done1));

    frame_decoder #(.IMG_W(W), .IMG_H(H), .RD_LATENCY(3)) dut_l3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(start_x), .i_pix_ready(1'b1),
        .o_pix_valid(v3), .o_pix_color(c3), .o_pix_h(h3), .o_pix_v(r3),
        .o_sram_addr(a3), .o_sram_rd(rd3), .i_sram_data(d3),
        .o_busy(busy3), .o_done(done3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_rd(input logic [19:0] a);
        case (a)
            20'd0:   return 16'h3210;
            20'd1:   return 16'h7654;
            default: return 16'hDEAD;
        endcase
    endfunction

    // SRAM models: data visible exactly RD_LATENCY cycles after the strobe, garbage otherwise.
    always @(posedge clk) begin
        p2[0] <= sram_rd ? mem_rd(sram_addr) : 16'hBAD0;
        p2[1] <= p2[0];
        p1    <= rd1 ? mem_rd(a1) : 16'hBAD1;
        p3[0] <= rd3 ? mem_rd(a3) : 16'hBAD3;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign sram_dat = p2[1];
    assign d1       = p1;
    assign d3       = p3[2];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int i, input bit timed);
        exp_t e;
        e.c   = i[3:0];
        e.h   = 2'(i % W);
        e.v   = 1'(i / W);
        e.off = !timed ? -1 : (PF ? 4 + i : (i < 4 ? 4 + i : 7 + i));
        q.push_back(e);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, int'(pix_vld), 0);
        chk({tag, "_color"}, int'(pix_col), 0);
        chk({tag, "_h"}, int'(pix_h), 0);
        chk({tag, "_v"}, int'(pix_row), 0);
        chk({tag, "_addr"}, int'(sram_addr), 0);
        chk({tag, "_rd"}, int'(sram_rd), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    task automatic run_frame(input bit toggle, input int restart_off, input bit with_x);
        bit fin;
        int k;
        for (int i = 0; i < 8; i++) push_exp(i, !toggle);
        done_cnt = 0;
        rd_cnt   = 0;
        rd_addrs.delete();
        exp_done  = toggle ? -1 : DONE_OFF;
        start     = 1'b1;
        start_cyc = cyc;
        if (with_x) begin
            start_x    = 1'b1;
            startx_cyc = cyc;
        end
        fin = 1'b0;
        for (int t = 0; t < 200 && !fin; t++) begin
            @(posedge clk); #1;
            start   = 1'b0;
            start_x = 1'b0;
            k = cyc - start_cyc;
            if (toggle) ready = (k % 4 == 0) || (k % 4 == 3);
            if (k == restart_off) start = 1'b1;
            if (done_cnt > 0) fin = 1'b1;
        end
        chk("frame_timeout", int'(fin), 1);
        ready = 1'b1;
        start = 1'b0;
        chk("done_pulses", done_cnt, 1);
        chk("idle_after_done", int'(busy), 0);
        chk("sb_empty", q.size(), 0);
        chk("rd_count", rd_cnt, 2);
        if (rd_addrs.size() == 2) begin
            chk("rd_addr0", int'(rd_addrs[0]), 0);
            chk("rd_addr1", int'(rd_addrs[1]), 1);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; ready = 1'b1; start_x = 1'b0;
        done_cnt = 0; rd_cnt = 0; exp_done = -1; start_cyc = 0; startx_cyc = 0; n1 = 0; n3 = 0;

        fork
            begin : monitor
                bit         hold_vld;
                logic [3:0] hc;
                logic [1:0] hh;
                logic [0:0] hv;
                exp_t       e;
                hold_vld = 1'b0;
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        hold_vld = 1'b0;
                    end else begin
                        if (pix_vld) begin
                            if (hold_vld) begin
                                chk("hold_color", int'(pix_col), int'(hc));
                                chk("hold_h", int'(pix_h), int'(hh));
                                chk("hold_v", int'(pix_row), int'(hv));
                            end
                            if (ready) begin
                                hold_vld = 1'b0;
                                if (q.size() == 0) begin
                                    chk("unexpected_pixel", 1, 0);
                                end else begin
                                    e = q.pop_front();
                                    chk("pix_color", int'(pix_col), int'(e.c));
                                    chk("pix_h", int'(pix_h), int'(e.h));
                                    chk("pix_v", int'(pix_row), int'(e.v));
                                    if (e.off >= 0) chk("pix_cycle", cyc - start_cyc, e.off);
                                end
                            end else begin
                                hold_vld = 1'b1;
                                hc = pix_col; hh = pix_h; hv = pix_row;
                            end
                        end else if (hold_vld) begin
                            chk("valid_dropped", 0, 1);
                            hold_vld = 1'b0;
                        end
                        if (done) begin
                            done_cnt++;
                            if (exp_done >= 0) chk("done_cycle", cyc - start_cyc, exp_done);
                        end
                        if (sram_rd) begin
                            rd_cnt++;
                            rd_addrs.push_back(sram_addr);
                        end
                        if (v1) begin
                            chk("l1_color", int'(c1), n1 % 8);
                            chk("l1_h", int'(h1), n1 % 4);
                            chk("l1_v", int'(r1), (n1 / 4) % 2);
                            if (n1 == 0) chk("l1_first_valid", cyc - startx_cyc, 3);
                            n1++;
                        end
                        if (v3) begin
                            chk("l3_color", int'(c3), n3 % 8);
                            chk("l3_h", int'(h3), n3 % 4);
                            chk("l3_v", int'(r3), (n3 / 4) % 2);
                            if (n3 == 0) chk("l3_first_valid", cyc - startx_cyc, 5);
                            n3++;
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Straight frame with ready held high (side DUTs run alongside).
        run_frame(1'b0, -1, 1'b1);
        @(posedge clk); #1;

        // Ready pattern 1,0,0,1: outputs must hold, nothing skipped or doubled.
        run_frame(1'b1, -1, 1'b0);
        @(posedge clk); #1;

        // Asynchronous reset while word1 is in flight, then a clean replay.
        for (int i = 0; i < 8; i++) push_exp(i, 1'b1);
        start = 1'b1;
        start_cyc = cyc;
        exp_done = -1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 50 && (cyc - start_cyc) < RST_OFF; t++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check_idle("midrst");
        chk("midrst_sb_left", q.size(), RST_LEFT);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(1'b0, -1, 1'b0);
        @(posedge clk); #1;

        // Start pulse mid-frame is ignored.
        run_frame(1'b0, 6, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        chk("l1_pixels", n1, 8);
        chk("l3_pixels", n3, 8);
        chk("stray_pixels", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
